izh_update_scheduler: RTL and testbench
=======================================

Name: izh_update_scheduler

Overview:
- Time-multiplexed Izhikevich neuron update engine.
- Sweeps a population stored in an external single-port-style state memory. For each neuron it reads (v, u, I), computes one Euler step using a single shared fixed-point multiplier and a single shared adder, applies the spike reset, and writes (v, u) back.
- Sits between the network-level timestep controller (start/done) and the neuron state RAM.
- Emits one spike event per firing neuron.

Parameters:
- N, 32, data width; sign-magnitude fixed point, bit N-1 = sign, magnitude N-1 bits.
- Q, 16, fractional bits.
- AW, 8, neuron address width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a sweep when idle.
- num_neurons, input, AW+1, neuron count; sampled on accepted start.
- a, b, c, d, dt, input, N each, model constants; sampled on accepted start.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse at end of sweep.
- rd_en, output, 1, memory read strobe.
- rd_addr, output, AW, read address.
- rd_v, rd_u, rd_i, input, N each, read data; valid exactly 1 cycle after rd_en.
- wr_en, output, 1, write strobe.
- wr_addr, output, AW, write address.
- wr_v, wr_u, output, N each, write data.
- spike_valid, output, 1, pulse coincident with wr_en for a firing neuron.
- spike_idx, output, AW, index of the firing neuron.

Behaviour:
- Reset: async. All outputs 0; FSM to IDLE; latched constants, count and temps cleared. Reset mid-sweep aborts the sweep; no further rd_en/wr_en, and no done pulse.
- Arithmetic is sign-magnitude Q16.16 throughout:
  - mult: magnitude product, bits [N-2+Q:Q] kept (truncating, no saturation); sign = XOR.
  - add: sign-magnitude add; exact cancellation yields +0.
  - Negation flips bit N-1 only.
- Constants: K004 = 0x00000A3D, K5 = 0x00050000, K140 = 0x008C0000, VPEAK = 0x001E0000.
- FSM states: IDLE, FETCH, LATCH, OP, SPIKE, WRITE, DONE.
  - IDLE: start with num_neurons > 0 → latch inputs, idx = 0, busy = 1, go to FETCH. start with num_neurons == 0 → go to DONE. start while busy is ignored.
  - FETCH: rd_en = 1, rd_addr = idx → LATCH.
  - LATCH: capture rd_v/rd_u/rd_i into v, u, i → OP with op = 0.
  - OP: exactly one op per cycle; op 0..13 registered, in this order:
    - t0 = v*v
    - t0 = t0*K004
    - t1 = v*K5
    - t0 = t0+t1
    - t0 = t0+K140
    - t0 = t0+(-u)
    - t0 = t0+i
    - t0 = t0*dt
    - vn = v+t0
    - t1 = b*v
    - t1 = t1+(-u)
    - t1 = t1*a
    - t1 = t1*dt
    - un = u+t1
    - After op 13 → SPIKE.
  - SPIKE: if vn >= VPEAK (signed compare; -0 < +0), set vn = c, un = un+d, fire flag = 1; else fire flag = 0. → WRITE.
  - WRITE: wr_en = 1, wr_addr = idx, wr_v = vn, wr_u = un; spike_valid = fire flag, spike_idx = idx. Then idx+1 == count → DONE, else idx++ → FETCH.
  - DONE: done = 1 for one cycle, busy = 0 → IDLE.
- Timing: 18 cycles per neuron (FETCH 1, LATCH 1, OP 14, SPIKE 1, WRITE 1). done is asserted 18·count + 1 cycles after the start cycle.
- Address sequencing: rd_addr/wr_addr ascend 0..count-1, no wrap. count = 2^AW is legal. Strobes, addresses and write data are registered outputs; wr_v/wr_u/spike_idx hold their last values when idle.
- Constant changes during a sweep have no effect until the next start.

Test Plan:
- Resting neuron:
  - Stimulus: count = 1, v = -65 (0x80410000), u = -13, I = 0, a = 0.02 (0x0000051E), b = 0.2 (0x00003333), c = -65, d = 8, dt = 0.1 (0x0000199A).
  - Required: wr_v ≈ -65.3 and wr_u ≈ -13, each within 0.01; spike_valid = 0; done at cycle 19.
- Firing neuron:
  - Stimulus: v = 35, u = 0, I = 0, same constants.
  - Required: wr_v = 0x80410000 exactly; wr_u ≈ 8.014 (±0.01); spike_valid = 1 with spike_idx = 0, coincident with wr_en.
- Sweep timing:
  - Stimulus: count = 4, memory model preloaded.
  - Required: rd_en at cycles 1, 19, 37, 55; wr_en at 18, 36, 54, 72 with addresses 0..3; done at 73; busy high for cycles 1..72.
- Start and empty sweep:
  - Stimulus: start pulse mid-sweep; separately, count = 0.
  - Required: mid-sweep start has no effect on addresses or the done time. count = 0 gives done the next cycle with no rd_en/wr_en.
- Reset abort:
  - Stimulus: rst asserted asynchronously during OP of neuron 1 in a count = 3 sweep.
  - Required: all outputs 0 immediately; no further writes and no done. A fresh start then completes normally from idx 0.
- Equality and sign edges:
  - Stimulus: I chosen so vn = 0x001E0000 exactly, then vn = 0x001DFFFF.
  - Required: the first spikes; the second does not.

Source files
------------

// File: rtl/izh_update_scheduler.sv
// Time-multiplexed Izhikevich neuron update engine: sweeps a neuron state RAM and
// applies one sign-magnitude Q16.16 Euler step per neuron through one shared multiplier and one shared adder.
module izh_update_scheduler #(
    parameter int N  = 32,
    parameter int Q  = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   num_neurons,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [N-1:0]  c,
    input  logic [N-1:0]  d,
    input  logic [N-1:0]  dt,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_v,
    input  logic [N-1:0]  rd_u,
    input  logic [N-1:0]  rd_i,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_v,
    output logic [N-1:0]  wr_u,
    output logic          spike_valid,
    output logic [AW-1:0] spike_idx,
    output logic [2:0]    dbg_state
);

    // Memory handshake: rd_en/rd_addr issue a read that always returns rd_v/rd_u/rd_i
    // exactly one cycle later (no backpressure); wr_en/wr_addr/wr_v/wr_u is a one-cycle
    // fire-and-forget write. spike_valid qualifies spike_idx in the same cycle as wr_en.

    localparam int PW = 2 * (N - 1);
    localparam logic [N-1:0] K004  = N'(32'h00000A3D);
    localparam logic [N-1:0] K5    = N'(32'h00050000);
    localparam logic [N-1:0] K140  = N'(32'h008C0000);
    localparam logic [N-1:0] VPEAK = N'(32'h001E0000);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_OP    = 3'd3,
        S_SPIKE = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state, state_next;

    logic [AW:0]   count;
    logic [AW-1:0] idx;
    logic [3:0]    op;
    logic [N-1:0]  k_a, k_b, k_c, k_d, k_dt;
    logic [N-1:0]  v, u, i_in, t0, t1, vn, un;

    logic          last;
    logic [N-1:0]  mul_x, mul_y, mul_res;
    logic [N-1:0]  add_x, add_y, add_res;
    logic [PW-1:0] mul_full;
    logic [N-1:0]  add_sum;
    logic          fire_now;

    assign dbg_state = state;
    assign last      = ((AW+1)'(idx) + (AW+1)'(1)) == count;

    function automatic logic [N-1:0] neg(input logic [N-1:0] x);
        return {~x[N-1], x[N-2:0]};
    endfunction

    // Operand select for the shared units; one op per cycle, SPIKE reuses the adder for un+d.
    always_comb begin
        mul_x = v;
        mul_y = v;
        add_x = t0;
        add_y = t1;
        case (op)
            4'd0:  begin mul_x = v;   mul_y = v;    end
            4'd1:  begin mul_x = t0;  mul_y = K004; end
            4'd2:  begin mul_x = v;   mul_y = K5;   end
            4'd3:  begin add_x = t0;  add_y = t1;   end
            4'd4:  begin add_x = t0;  add_y = K140; end
            4'd5:  begin add_x = t0;  add_y = neg(u); end
            4'd6:  begin add_x = t0;  add_y = i_in; end
            4'd7:  begin mul_x = t0;  mul_y = k_dt; end
            4'd8:  begin add_x = v;   add_y = t0;   end
            4'd9:  begin mul_x = k_b; mul_y = v;    end
            4'd10: begin add_x = t1;  add_y = neg(u); end
            4'd11: begin mul_x = t1;  mul_y = k_a;  end
            4'd12: begin mul_x = t1;  mul_y = k_dt; end
            4'd13: begin add_x = u;   add_y = t1;   end
            default: ;
        endcase
        if (state == S_SPIKE) begin
            add_x = un;
            add_y = k_d;
        end
    end

    // Truncating Q16.16 magnitude product; the sign is the XOR of operand signs.
    assign mul_full = PW'(mul_x[N-2:0]) * PW'(mul_y[N-2:0]);
    assign mul_res  = {mul_x[N-1] ^ mul_y[N-1], mul_full[N-2+Q:Q]};
    assign add_sum  = N'(add_x[N-2:0]) + N'(add_y[N-2:0]);

    always_comb begin
        add_res = '0;
        if (add_x[N-1] == add_y[N-1]) begin
            add_res = {add_x[N-1], add_sum[N-2:0]};
        end else if (add_x[N-2:0] > add_y[N-2:0]) begin
            add_res = {add_x[N-1], add_x[N-2:0] - add_y[N-2:0]};
        end else if (add_y[N-2:0] > add_x[N-2:0]) begin
            add_res = {add_y[N-1], add_y[N-2:0] - add_x[N-2:0]};
        end
    end

    // VPEAK is positive, so any negative vn (including -0) is below it.
    assign fire_now = !vn[N-1] && (vn[N-2:0] >= VPEAK[N-2:0]);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (num_neurons != '0) ? S_FETCH : S_DONE;
            S_FETCH: state_next = S_LATCH;
            S_LATCH: state_next = S_OP;
            S_OP:    if (op == 4'd13) state_next = S_SPIKE;
            S_SPIKE: state_next = S_WRITE;
            S_WRITE: state_next = last ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_v        <= '0;
            wr_u        <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            count       <= '0;
            idx         <= '0;
            op          <= '0;
            k_a         <= '0;
            k_b         <= '0;
            k_c         <= '0;
            k_d         <= '0;
            k_dt        <= '0;
            v           <= '0;
            u           <= '0;
            i_in        <= '0;
            t0          <= '0;
            t1          <= '0;
            vn          <= '0;
            un          <= '0;
        end else begin
            rd_en       <= (state_next == S_FETCH);
            wr_en       <= (state == S_SPIKE);
            done        <= (state_next == S_DONE);
            busy        <= state_next inside {S_FETCH, S_LATCH, S_OP, S_SPIKE, S_WRITE};
            spike_valid <= (state == S_SPIKE) && fire_now;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count   <= num_neurons;
                        k_a     <= a;
                        k_b     <= b;
                        k_c     <= c;
                        k_d     <= d;
                        k_dt    <= dt;
                        idx     <= '0;
                        if (num_neurons != '0) rd_addr <= '0;
                    end
                end
                S_LATCH: begin
                    v    <= rd_v;
                    u    <= rd_u;
                    i_in <= rd_i;
                    op   <= '0;
                end
                S_OP: begin
                    op <= op + 4'd1;
                    case (op)
                        4'd0, 4'd1, 4'd7:          t0 <= mul_res;
                        4'd2, 4'd9, 4'd11, 4'd12:  t1 <= mul_res;
                        4'd3, 4'd4, 4'd5, 4'd6:    t0 <= add_res;
                        4'd8:                      vn <= add_res;
                        4'd10:                     t1 <= add_res;
                        4'd13:                     un <= add_res;
                        default: ;
                    endcase
                end
                S_SPIKE: begin
                    wr_addr   <= idx;
                    spike_idx <= idx;
                    if (fire_now) begin
                        vn   <= k_c;
                        un   <= add_res;
                        wr_v <= k_c;
                        wr_u <= add_res;
                    end else begin
                        wr_v <= vn;
                        wr_u <= un;
                    end
                end
                S_WRITE: begin
                    if (!last) begin
                        idx     <= idx + AW'(1);
                        rd_addr <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_izh_update_scheduler.sv
// Bench for izh_update_scheduler: RAM model, sign-magnitude reference model,
// table of single-neuron vectors, and multi-neuron sweep / abort sequences.
module tb_izh_update_scheduler;

    localparam int N  = 32;
    localparam int AW = 8;
    localparam int W  = AW + 2 * N + 1;

    localparam logic [31:0] C_A   = 32'h0000051E;
    localparam logic [31:0] C_B   = 32'h00003333;
    localparam logic [31:0] C_C   = 32'h80410000;
    localparam logic [31:0] C_D   = 32'h00080000;
    localparam logic [31:0] C_DT  = 32'h0000199A;
    localparam logic [31:0] C_DT1 = 32'h00010000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_neurons;
    logic [N-1:0]  a, b, c, d, dt;
    logic          busy, done, rd_en, wr_en, spike_valid;
    logic [AW-1:0] rd_addr, wr_addr, spike_idx;
    logic [N-1:0]  rd_v, rd_u, rd_i, wr_v, wr_u;
    logic [2:0]    dbg_state;

    izh_update_scheduler #(.N(N), .Q(16), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
        .a(a), .b(b), .c(c), .d(d), .dt(dt),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_v(rd_v), .rd_u(rd_u), .rd_i(rd_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_v(wr_v), .wr_u(wr_u),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // state RAM model: read data returns one cycle after rd_en
    logic [N-1:0] mem_v [256];
    logic [N-1:0] mem_u [256];
    logic [N-1:0] mem_i [256];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_v <= mem_v[rd_addr];
            rd_u <= mem_u[rd_addr];
            rd_i <= mem_i[rd_addr];
        end
    end

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [N-1:0] cur_a, cur_b, cur_c, cur_d, cur_dt;
    logic [N-1:0] last_wv, last_wu;
    logic         last_spk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_val);
        end
    endtask

    task automatic check_real(input string name, input real act, input real exp_val, input real tol);
        real diff;
        diff = act - exp_val;
        if (diff < 0.0) diff = -diff;
        checks++;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %f expected %f (tol %f)", name, act, exp_val, tol);
        end
    endtask

    // reference arithmetic, written over signed integers
    function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = (longint'(x[30:0]) * longint'(y[30:0])) >>> 16;
        return {x[31] ^ y[31], 31'(p)};
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, s;
        if (x[31] == y[31]) return {x[31], 31'(longint'(x[30:0]) + longint'(y[30:0]))};
        sx = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
        sy = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
        s  = sx + sy;
        if (s == 0) return 32'h0;
        if (s < 0)  return {1'b1, 31'(-s)};
        return {1'b0, 31'(s)};
    endfunction

    function automatic logic [31:0] m_neg(input logic [31:0] x);
        return x ^ 32'h80000000;
    endfunction

    function automatic real sm_to_real(input logic [31:0] x);
        real m;
        m = real'(x[30:0]) / 65536.0;
        return x[31] ? -m : m;
    endfunction

    task automatic model_neuron(input logic [31:0] v, input logic [31:0] u, input logic [31:0] i,
                                output logic [31:0] vn, output logic [31:0] un, output logic spk);
        logic [31:0] x0, x1;
        longint sv;
        x0 = m_mul(v, v);
        x0 = m_mul(x0, 32'h00000A3D);
        x1 = m_mul(v, 32'h00050000);
        x0 = m_add(x0, x1);
        x0 = m_add(x0, 32'h008C0000);
        x0 = m_add(x0, m_neg(u));
        x0 = m_add(x0, i);
        x0 = m_mul(x0, cur_dt);
        vn = m_add(v, x0);
        x1 = m_mul(cur_b, v);
        x1 = m_add(x1, m_neg(u));
        x1 = m_mul(x1, cur_a);
        x1 = m_mul(x1, cur_dt);
        un = m_add(u, x1);
        sv = vn[31] ? -longint'(vn[30:0]) : longint'(vn[30:0]);
        spk = (sv >= 64'sh1E0000);
        if (spk) begin
            vn = cur_c;
            un = m_add(un, cur_d);
        end
    endtask

    // One sweep of n neurons; every cycle the strobes are checked against the
    // 18-cycle-per-neuron schedule and writes are scored against exp_q.
    task automatic run_sweep(input int n, input int mid_start_rel, input int abort_rel);
        logic [31:0] evn, eun;
        logic espk;
        logic [W-1:0] e;
        int lim;
        logic exp_rd, exp_wr, exp_busy, exp_done;
        for (int k = 0; k < n; k++) begin
            model_neuron(mem_v[k], mem_u[k], mem_i[k], evn, eun, espk);
            exp_q.push_back({AW'(k), evn, eun, espk});
        end
        @(negedge clk);
        num_neurons = (AW+1)'(n);
        a = cur_a; b = cur_b; c = cur_c; d = cur_d; dt = cur_dt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lim = 18 * n + 3;
        for (int rel = 1; rel <= lim; rel++) begin
            @(negedge clk);
            exp_rd   = (rel <= 18 * n) && ((rel - 1) % 18 == 0);
            exp_wr   = (rel >= 18) && (rel <= 18 * n) && (rel % 18 == 0);
            exp_busy = (rel <= 18 * n);
            exp_done = (rel == 18 * n + 1);
            check($sformatf("strobes{rd,wr,busy,done}@%0d", rel),
                  {rd_en, wr_en, busy, done}, {exp_rd, exp_wr, exp_busy, exp_done});
            if (rd_en && exp_rd) check("rd_addr", rd_addr, AW'((rel - 1) / 18));
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_unexpected_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("write{addr,v,u,spike}", {wr_addr, wr_v, wr_u, spike_valid}, e);
                    check("spike_idx", spike_idx, e[W-1 -: AW]);
                    last_wv  = wr_v;
                    last_wu  = wr_u;
                    last_spk = spike_valid;
                end
            end
            if (mid_start_rel != 0 && rel == mid_start_rel) begin
                start = 1'b1;
                num_neurons = (AW+1)'(2);
                a = $urandom; b = $urandom; c = $urandom; d = $urandom; dt = $urandom;
            end
            if (mid_start_rel != 0 && rel == mid_start_rel + 1) start = 1'b0;
            if (rel == abort_rel) begin
                #2 rst = 1'b1;
                #1;
                check("abort_ctrl{busy,done,rd_en,wr_en,spike_valid,state}",
                      {busy, done, rd_en, wr_en, spike_valid, dbg_state}, 8'h0);
                check("abort_data{rd_addr,wr_addr,spike_idx,wr_v,wr_u}",
                      {rd_addr, wr_addr, spike_idx, wr_v, wr_u}, 88'h0);
                check("abort_pending_writes", exp_q.size(), 2);
                exp_q.delete();
                return;
            end
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] v, u, i, dtv;
        logic        spk;
        real         wv, wu;
    } vec_t;

    vec_t tbl[4];
    int   stray;

    initial begin
        tbl[0] = '{"resting",   32'h80410000, 32'h800D0000, 32'h00000000, C_DT,  1'b0, -65.3,   -13.0};
        tbl[1] = '{"firing",    32'h00230000, 32'h00000000, 32'h00000000, C_DT,  1'b1, -65.0,   8.014};
        tbl[2] = '{"vn_eq_peak", 32'h00000000, 32'h00000000, 32'h806E0000, C_DT1, 1'b1, -65.0,   8.0};
        tbl[3] = '{"vn_below",  32'h00000000, 32'h00000000, 32'h806E0001, C_DT1, 1'b0, 29.99998, 0.0};

        rst = 1'b1; start = 1'b0; num_neurons = '0;
        a = '0; b = '0; c = '0; d = '0; dt = '0;
        cur_a = C_A; cur_b = C_B; cur_c = C_C; cur_d = C_D; cur_dt = C_DT;
        repeat (3) @(negedge clk);
        check("reset_ctrl{busy,done,rd_en,wr_en,spike_valid,state}",
              {busy, done, rd_en, wr_en, spike_valid, dbg_state}, 8'h0);
        check("reset_data{rd_addr,wr_addr,spike_idx,wr_v,wr_u}",
              {rd_addr, wr_addr, spike_idx, wr_v, wr_u}, 88'h0);
        rst = 1'b0;
        @(negedge clk);

        // single-neuron vectors
        for (int k = 0; k < 4; k++) begin
            mem_v[0] = tbl[k].v;
            mem_u[0] = tbl[k].u;
            mem_i[0] = tbl[k].i;
            cur_dt   = tbl[k].dtv;
            run_sweep(1, 0, 0);
            check({tbl[k].name, "_spike"}, last_spk, tbl[k].spk);
            check_real({tbl[k].name, "_wr_v"}, sm_to_real(last_wv), tbl[k].wv, 0.01);
            check_real({tbl[k].name, "_wr_u"}, sm_to_real(last_wu), tbl[k].wu, 0.01);
        end
        cur_dt = C_DT;

        // randomised population, plain sweep then sweep with a mid-sweep start
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                mem_v[k] = {1'($urandom_range(1, 0)), 31'($urandom_range(32'h00500000, 0))};
                mem_u[k] = {1'($urandom_range(1, 0)), 31'($urandom_range(32'h00140000, 0))};
                mem_i[k] = {1'($urandom_range(1, 0)), 31'($urandom_range(32'h00140000, 0))};
            end
            mem_v[3] = 32'h00280000;
            run_sweep(4, (pass == 1) ? 25 : 0, 0);
        end

        // empty sweep
        run_sweep(0, 0, 0);

        // asynchronous reset during OP of neuron 1, then a clean rerun
        run_sweep(3, 0, 25);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rd_en || wr_en || done || busy) stray++;
        end
        check("no_activity_after_abort", stray, 0);
        run_sweep(3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
